gpu_bg_block_buffer: RTL

GPU_BG_BLOCK_BUFFER -- requirements
Module: gpu_bg_block_buffer

---
 rtl/gpu_bg_block_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gpu_bg_block_buffer.sv
// Background block buffer: keeps one open pixel block, optionally preloads it
// for blending, and hands finished blocks to a one-entry save buffer.
module gpu_bg_block_buffer #(
   parameter int unsigned LANES     = 2,
   parameter int unsigned BLOCK_PIX = 16,
   parameter int unsigned ADR_W     = 15,
   localparam int unsigned GROUPS   = BLOCK_PIX / LANES,
   localparam int unsigned SLOT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
   input  logic                    clk,
   input  logic                    i_nrst,
   input  logic                    i_blendEnable,
   input  logic                    i_flush,
   input  logic                    i_pixValid,
   output logic                    o_pixReady,
   input  logic [ADR_W-1:0]        i_pixAdr,
   input  logic [SLOT_W-1:0]       i_pixSlot,
   input  logic [LANES*16-1:0]     i_pixData,
   input  logic [LANES-1:0]        i_pixMask,
   output logic [LANES*16-1:0]     o_bgPix,
   output logic                    o_loadReq,
   output logic [ADR_W-1:0]        o_loadAdr,
   input  logic                    i_loadValid,
   input  logic [BLOCK_PIX*16-1:0] i_loadData,
   output logic                    o_saveReq,
   output logic [ADR_W-1:0]        o_saveAdr,
   output logic [BLOCK_PIX*16-1:0] o_saveData,
   output logic [BLOCK_PIX-1:0]    o_saveMask,
   input  logic                    i_saveAck,
   output logic                    o_busy
);
   localparam int unsigned PIX_W = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;

   typedef enum logic [1:0] {IDLE, SWITCH, LOADING, OPEN} state_t;

   state_t                  state, stateNxt;
   logic [ADR_W-1:0]        curAdr;
   logic [BLOCK_PIX*16-1:0] blkData;
   logic [BLOCK_PIX-1:0]    blkMask;
   logic                    saveFull;
   logic [ADR_W-1:0]        saveAdr;
   logic [BLOCK_PIX*16-1:0] saveData;
   logic [BLOCK_PIX-1:0]    saveMask;

   logic             canXfer_c, doXfer_c, doWrite_c, doLoad_c, takeAdr_c, clearMask_c;
   logic [PIX_W-1:0] slotBase_c;

   // First pixel index addressed by the incoming lane group
   assign slotBase_c = (GROUPS > 1) ? PIX_W'(PIX_W'(i_pixSlot) * PIX_W'(LANES)) : '0;

   // An empty block never needs the save buffer; otherwise it must be free or freeing now
   assign canXfer_c = (blkMask == '0) || !saveFull || i_saveAck;

   // Next state and per-cycle actions
   always_comb begin
      stateNxt    = state;
      doXfer_c    = 1'b0;
      doWrite_c   = 1'b0;
      doLoad_c    = 1'b0;
      takeAdr_c   = 1'b0;
      clearMask_c = 1'b0;
      case (state)
         IDLE: begin
            if (i_pixValid) stateNxt = SWITCH;
         end
         SWITCH: begin
            if (canXfer_c) begin
               doXfer_c    = (blkMask != '0);
               clearMask_c = 1'b1;
               takeAdr_c   = 1'b1;
               stateNxt    = i_blendEnable ? LOADING : OPEN;
            end
         end
         LOADING: begin
            if (i_loadValid) begin
               doLoad_c = 1'b1;
               stateNxt = OPEN;
            end
         end
         OPEN: begin
            if (i_flush) begin
               if (canXfer_c) begin
                  doXfer_c    = (blkMask != '0);
                  clearMask_c = 1'b1;
                  stateNxt    = IDLE;
               end
            end else if (i_pixValid) begin
               if (i_pixAdr == curAdr) doWrite_c = 1'b1;
               else                    stateNxt  = SWITCH;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) state <= IDLE;
      else         state <= stateNxt;
   end

   // Address of the open block, captured when switching
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst)        curAdr <= '0;
      else if (takeAdr_c) curAdr <= i_pixAdr;
   end

   // Block contents and written-pixel mask
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         blkData <= '0;
         blkMask <= '0;
      end else begin
         if (doLoad_c)    blkData <= i_loadData;
         if (clearMask_c) blkMask <= '0;
         if (doWrite_c) begin
            for (int unsigned k = 0; k < LANES; k++) begin
               if (i_pixMask[k]) begin
                  blkData[(32'(slotBase_c) + k) * 32'd16 +: 16] <= i_pixData[k*16 +: 16];
                  blkMask[slotBase_c + PIX_W'(k)]               <= 1'b1;
               end
            end
         end
      end
   end

   // One-entry save buffer; a same-edge ack and transfer simply reloads it
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         saveFull <= 1'b0;
         saveAdr  <= '0;
         saveData <= '0;
         saveMask <= '0;
      end else if (doXfer_c) begin
         saveFull <= 1'b1;
         saveAdr  <= curAdr;
         saveData <= blkData;
         saveMask <= blkMask;
      end else if (i_saveAck) begin
         saveFull <= 1'b0;
      end
   end

   assign o_pixReady = doWrite_c;
   assign o_bgPix    = blkData[32'(slotBase_c) * 32'd16 +: LANES*16];
   assign o_loadReq  = (state == LOADING);
   assign o_loadAdr  = curAdr;
   assign o_saveReq  = saveFull;
   assign o_saveAdr  = saveAdr;
   assign o_saveData = saveData;
   assign o_saveMask = saveMask;
   assign o_busy     = (state != IDLE) || saveFull;

endmodule
